// File: rtl/register.sv
// ---------------------------------------------------------------------------
// register -- single WIDTH-bit storage word with two tri-state read ports.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous, active-high reset; clears the stored word
//   WriteReg     write enable; captures D on the rising edge
//   ReadEnable1  enables Bitline1 to drive the read value
//   ReadEnable2  enables Bitline2 to drive the read value
//   D            write data, WIDTH bits
//   Bitline1     tri-state read port 1 (high-Z when not enabled)
//   Bitline2     tri-state read port 2 (high-Z when not enabled)
//
// Configuration:
//   REGISTER_BYPASS_EN  when defined, a write in progress (WriteReg=1,
//                       rst=0) is forwarded combinationally from D to the
//                       enabled bitlines. Undefined: bitlines always show
//                       the stored word.
// ---------------------------------------------------------------------------
module register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WriteReg,
    input  logic             ReadEnable1,
    input  logic             ReadEnable2,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Bitline1,
    output logic [WIDTH-1:0] Bitline2
);

    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] read_value;

    // Reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= '0;
        end else if (WriteReg) begin
            Q <= D;
        end
    end

`ifdef REGISTER_BYPASS_EN
    // Write-through forwarding; suppressed during reset so reads show the
    // stored word while it is being cleared.
    assign read_value = (WriteReg && !rst) ? D : Q;
`else
    assign read_value = Q;
`endif

    // Whole-word drive or whole-word release, so shared bitlines never see
    // a partially driven word.
    assign Bitline1 = ReadEnable1 ? read_value : 'z;
    assign Bitline2 = ReadEnable2 ? read_value : 'z;

endmodule

// File: tb/tb_register.sv
// ---------------------------------------------------------------------------
// tb_register -- self-checking bench for register (WIDTH=16).
// Two identical instances share all inputs; one has pulled-up bitlines and
// the other pulled-down bitlines, so a released (high-Z) port reads FFFF on
// one and 0000 on the other, while a driven port reads the same on both.
// ---------------------------------------------------------------------------
module tb_register;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         we;
    logic         re1;
    logic         re2;
    logic [W-1:0] d;

    tri1  [W-1:0] bl1_u;
    tri1  [W-1:0] bl2_u;
    tri0  [W-1:0] bl1_d;
    tri0  [W-1:0] bl2_d;

    int checks = 0;
    int errors = 0;

    // Reference state: the word the register should currently hold.
    logic [W-1:0] q_m;

    register #(.WIDTH(W)) u_pu (
        .clk(clk), .rst(rst), .WriteReg(we),
        .ReadEnable1(re1), .ReadEnable2(re2), .D(d),
        .Bitline1(bl1_u), .Bitline2(bl2_u)
    );

    register #(.WIDTH(W)) u_pd (
        .clk(clk), .rst(rst), .WriteReg(we),
        .ReadEnable1(re1), .ReadEnable2(re2), .D(d),
        .Bitline1(bl1_d), .Bitline2(bl2_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value the enabled bitlines should show right now.
    function automatic logic [W-1:0] model_read();
`ifdef REGISTER_BYPASS_EN
        if (we && !rst) return d;
`endif
        return q_m;
    endfunction

    task automatic chk(input string tag, input logic en, input logic [W-1:0] exp,
                       input logic [W-1:0] pu, input logic [W-1:0] pd);
        logic [W-1:0] eu;
        logic [W-1:0] ed;
        eu = en ? exp : 16'hFFFF;
        ed = en ? exp : 16'h0000;
        checks++;
        assert (pu === eu && pd === ed) else begin
            errors++;
            $error("FAIL %s: observed pull-up=%h pull-down=%h, expected %s", tag, pu, pd,
                   en ? $sformatf("%h", exp) : "ZZZZ");
        end
    endtask

    task automatic chk_both(input string tag);
        chk({tag, "/bl1"}, re1, model_read(), bl1_u, bl1_d);
        chk({tag, "/bl2"}, re2, model_read(), bl2_u, bl2_d);
    endtask

    // Apply inputs away from the edge, check the combinational read, take the
    // edge, update the reference, then check again after the edge.
    task automatic cycle(input string tag, input logic r, input logic w,
                         input logic e1, input logic e2, input logic [W-1:0] data);
        @(negedge clk);
        rst = r; we = w; re1 = e1; re2 = e2; d = data;
        #1;
        chk_both({tag, "/pre"});
        @(posedge clk);
        if (r) q_m = '0;
        else if (w) q_m = data;
        #1;
        chk_both({tag, "/post"});
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re1 = 1'b0; re2 = 1'b0; d = 16'hFFFF;
        q_m = '0;

        // First reset edge; no checks before it since Q is unknown.
        @(posedge clk);
        #1;

        // Read after reset: Bitline1 shows 0000, Bitline2 released.
        cycle("rst_read", 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
        // Write FFFF with port 1 enabled (bypass visible pre-edge if built in).
        cycle("wr_ffff", 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF);
        // D changes while not writing: no effect.
        cycle("hold_p1", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        cycle("hold_p2", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        // Both ports, write A5A5.
        cycle("both_a5", 1'b0, 1'b1, 1'b1, 1'b1, 16'hA5A5);
        // Reset beats simultaneous write.
        cycle("rst_wr", 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234);
        cycle("rst_rd", 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
        // Both ports disabled across several writes.
        cycle("off_0001", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001);
        cycle("off_8000", 1'b0, 1'b1, 1'b0, 1'b0, 16'h8000);
        cycle("off_ffff", 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
        cycle("off_rd", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);

        // Randomized operation.
        for (int i = 0; i < 300; i++) begin
            cycle("rand", ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                  1'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register.md
REGISTER -- requirements
Module: register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data word width in bits; the block SHALL be verified at 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, and all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, which SHALL be synchronous and active-high.
REQ-004 The block SHALL have port WriteReg, input, 1 bit: the write enable, which captures D at the rising edge.
REQ-005 The block SHALL have port ReadEnable1, input, 1 bit: the enable that makes Bitline1 drive.
REQ-006 The block SHALL have port ReadEnable2, input, 1 bit: the enable that makes Bitline2 drive.
REQ-007 The block SHALL have port D, input, WIDTH bits: the write data.
REQ-008 The block SHALL have port Bitline1, tri-state output, WIDTH bits: read port 1, shareable with other registers' bitlines.
REQ-009 The block SHALL have port Bitline2, tri-state output, WIDTH bits: read port 2, shareable with other registers' bitlines.

Function
REQ-010 The block SHALL hold one WIDTH-bit stored word Q.
REQ-011 At a rising clk edge with rst=0 and WriteReg=1, Q SHALL become D, with 1-cycle write latency.
REQ-012 At a rising clk edge with rst=0 and WriteReg=0, Q SHALL hold its value.
REQ-013 Bitline1 SHALL drive the read value whenever ReadEnable1=1, and SHALL be all high-Z whenever ReadEnable1=0; this path SHALL be combinational with zero-cycle read latency.
REQ-014 Bitline2 SHALL behave identically to Bitline1 under control of ReadEnable2.
REQ-015 When both read enables are asserted at once, both bitlines SHALL drive the same value with no interaction between ports.
REQ-016 The read value SHALL be Q unless REQ-022 applies.
REQ-017 Each bitline SHALL be driven only as a whole word and SHALL never be partially driven or show X while its enable is stable.
REQ-018 Changes on D while WriteReg=0 SHALL have no effect on Q or on either bitline.

Reset
REQ-019 At a rising clk edge with rst=1, Q SHALL become 0 regardless of WriteReg and D, and reset SHALL take priority over a simultaneous write.
REQ-020 Reset SHALL NOT affect the bitline enables: a bitline whose enable is asserted during reset SHALL drive Q, which reads 0 from the first reset edge onward.
REQ-021 Asserting rst mid-operation SHALL discard any write requested on that same edge.

Configuration
REQ-022 With macro REGISTER_BYPASS_EN defined, when WriteReg=1 and rst=0, any enabled bitline SHALL drive D combinationally (write-through bypass) instead of Q.
REQ-023 With REGISTER_BYPASS_EN undefined, an enabled bitline SHALL always drive Q, so data written this cycle is readable only from the next cycle.
REQ-024 With REGISTER_BYPASS_EN defined and rst=1, enabled bitlines SHALL drive Q, with no bypass during reset.

Verification
REQ-025 Scenario: rst=1 for one edge with D=FFFF and WriteReg=0, then ReadEnable1=1 -> Bitline1=0000 and Bitline2=ZZZZ.
REQ-026 Scenario: rst=0, WriteReg=1, D=FFFF, one edge, then WriteReg=0, D=0000, ReadEnable1=1 -> Bitline1=FFFF and Bitline2=ZZZZ.
REQ-027 Scenario: next cycle ReadEnable1=0 and ReadEnable2=1 -> Bitline1=ZZZZ and Bitline2=FFFF, with Q unchanged by D=0000.
REQ-028 Scenario: both enables=1, WriteReg=1, D=A5A5 -> before the edge both bitlines read FFFF without the macro or A5A5 with it, and after the edge both read A5A5.
REQ-029 Scenario: rst=1 and WriteReg=1 with D=1234 on the same edge -> Q=0000 and the enabled bitline reads 0000.
REQ-030 Scenario: both enables=0 across writes of 0001, 8000 and FFFF -> both bitlines remain ZZZZ throughout.
